uart_mmio_ctrl: RTL
===================

# uart_mmio_ctrl

CPU-facing memory-mapped UART controller that sits between the core's data bus and the `async_transmitter` / `async_receiver` pair. It buffers outgoing bytes in a TX FIFO and hands them to the transmitter with a `TxD_start` pulse. It drains the receiver's `RxD_data_ready` / `RxD_clear` handshake into an RX FIFO. Software sees two registers: DATA at `0xBFD003F8` and STATUS at `0xBFD003FC`, decoded upstream into `addr_sel`.

## Interface
Parameters:
- `TX_DEPTH`, 4 — TX FIFO entries; power of 2, at least 2.
- `RX_DEPTH`, 4 — RX FIFO entries; power of 2, at least 2.

Ports:
- `clk`  in  1  — single clock domain; the transmitter and receiver use the same clock.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `req`  in  1  — one-cycle bus access strobe.
- `we`  in  1  — 1 = write, 0 = read; sampled with `req`.
- `addr_sel`  in  1  — 0 = DATA, 1 = STATUS.
- `wdata`  in  8  — write byte.
- `rdata`  out  32  — read result; registered.
- `rvalid`  out  1  — read result valid; pulses one cycle after a read `req`.
- `TxD_start`  out  1  — one-cycle launch pulse to the transmitter.
- `TxD_data`  out  8  — byte to send; held stable while `TxD_start` is high.
- `TxD_busy`  in  1  — transmitter busy.
- `RxD_data_ready`  in  1  — receiver holds a completed byte.
- `RxD_data`  in  8  — received byte.
- `RxD_clear`  out  1  — one-cycle acknowledge to the receiver.

## Operation
**Reset:** all outputs are 0, both FIFOs are empty, both FSMs are idle, and `tx_ovf` is 0.

**DATA write:**
- Pushes `wdata` into the TX FIFO when it is not full.
- When the FIFO is full, the byte is dropped and sticky `tx_ovf` is set.

**DATA read:**
- RX FIFO non-empty: `rdata = {24'b0, head}` and the head is popped.
- RX FIFO empty: `rdata = 0` and nothing is popped.

**STATUS read** returns `rdata = {28'b0, tx_idle, tx_ovf, rx_nonempty, tx_notfull}`:
- `tx_idle` = TX FIFO empty, TX FSM in T_IDLE, and `!TxD_busy`.
- The read returns the current `tx_ovf` and then clears it.
- If an overflowing write lands in the same cycle as the read, `tx_ovf` ends up set.

**STATUS write:** ignored.

**TX FSM (T_IDLE, T_START, T_HOLD):**
- T_IDLE: when the TX FIFO is non-empty and `!TxD_busy`, pop the head into the `TxD_data` register and go to T_START.
- T_START: `TxD_start` = 1 for exactly this cycle; go to T_HOLD.
- T_HOLD: go to T_IDLE when `!TxD_busy`.
  - The transmitter raises busy on the edge that ends T_START, so T_HOLD always sees busy high on its first cycle.

**RX FSM (R_IDLE, R_CLEAR):**
- R_IDLE: when `RxD_data_ready` and the RX FIFO is not full, push `RxD_data` and go to R_CLEAR.
- R_CLEAR: `RxD_clear` = 1 for exactly this cycle; return to R_IDLE.
- When the RX FIFO is full, `RxD_clear` is withheld. The receiver keeps ready high, which is backpressure.
  - A further frame arriving meanwhile overwrites the receiver's `RxD_data`. This is a documented overrun and is not flagged.

**FIFOs:**
- Pointers are `log2(DEPTH)+1` bits wide and wrap naturally.
- Full = MSBs differ and the lower bits are equal; empty = pointers equal.
- Full and empty are evaluated on pre-cycle state:
  - push on full is refused even when a pop occurs in the same cycle;
  - push and pop on a non-full, non-empty FIFO both complete;
  - push and pop on an empty FIFO: only the push completes (no pop occurs).

## Timing
- Bus write in cycle N takes effect at the edge ending cycle N.
- Read `req` in cycle N gives `rdata` / `rvalid` in cycle N+1. `rdata` holds its value until the next read; `rvalid` is 0 otherwise.
- TX launch latency: a write to an empty FIFO in cycle N with an idle transmitter gives `TxD_start` in cycle N+2 (T_IDLE pop in N+1, T_START in N+2).
- Back-to-back bytes: the next `TxD_start` comes no sooner than 2 cycles after `TxD_busy` falls.
- RX latency: `RxD_data_ready` high in cycle N with room in the FIFO gives a push at the end of N, `RxD_clear` in N+1, and STATUS `rx_nonempty` = 1 readable from cycle N+1.
- A byte completing in the receiver during the R_CLEAR cycle is lost, because the receiver gives clear priority. This is accepted.
- Reset mid-frame:
  - The transmitter and receiver are not reset by `rst_n`, so an in-flight frame completes.
  - After `rst_n` rises, T_IDLE waits for `!TxD_busy` before the next launch.
  - A pending `RxD_data_ready` is captured normally.

## Test plan
- **Single TX:** write `0x41` to DATA with the transmitter idle → `TxD_start` pulses exactly once, 2 cycles later, with `TxD_data` = `0x41`; the serial line shows start, `0x41` LSB-first, stop; STATUS then reads `0x9`.
- **TX overflow:** with the transmitter held busy, write 5 bytes (`0x01`..`0x05`) with `TX_DEPTH` = 4 → STATUS reads `0x4` (`tx_ovf` set, full); bytes `0x01`..`0x04` are sent in order and `0x05` is dropped; a second STATUS read has bit2 = 0.
- **RX path:** drive `0x5A` serially into the receiver → exactly one `RxD_clear` pulse; STATUS bit1 = 1; a DATA read returns `0x0000005A`; a second DATA read returns `0x00000000`.
- **RX backpressure:** deliver 5 frames with no reads and `RX_DEPTH` = 4 → 4 entries are captured; `RxD_clear` is withheld on the 5th; one DATA read frees space and the pending byte is captured the following cycle.
- **Loopback:** connect `TxD` to `RxD` and write `0x00`, `0xFF`, `0xA5` → DATA reads return the same three bytes in order.
- **Async reset:** assert `rst_n` = 0 mid-T_HOLD with 2 bytes queued → all outputs 0 immediately and the FIFOs are empty; after release, no `TxD_start` occurs until the in-flight frame's `TxD_busy` falls.

Source files
------------

// File: rtl/uart_mmio_ctrl_if.sv
// Bus-side interface of uart_mmio_ctrl.
// The CPU (master) issues one-cycle accesses. The controller (slave) answers
// every read one cycle later.
//   req      - one-cycle access strobe
//   we       - 1 = write, 0 = read, sampled with req
//   addr_sel - 0 = DATA register, 1 = STATUS register
//   wdata    - write byte
//   rdata    - registered read result, held until the next read
//   rvalid   - one-cycle pulse marking rdata as fresh
interface uart_mmio_ctrl_if;
  logic        req;
  logic        we;
  logic        addr_sel;
  logic [7:0]  wdata;
  logic [31:0] rdata;
  logic        rvalid;

  modport master (
    output req, we, addr_sel, wdata,
    input  rdata, rvalid
  );

  modport slave (
    input  req, we, addr_sel, wdata,
    output rdata, rvalid
  );
endinterface

// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped UART controller between the CPU data bus and an
// async_transmitter / async_receiver pair that shares this clock.
// Outgoing bytes are queued in a TX FIFO and launched with a one-cycle
// TxD_start pulse. Received bytes are drained through the RxD_data_ready /
// RxD_clear handshake into an RX FIFO.
//   clk, rst_n     - clock; asynchronous active-low reset
//   bus (slave)    - req/we/addr_sel/wdata in, rdata/rvalid out
//   TxD_start      - one-cycle launch pulse; TxD_data held while it is high
//   TxD_data       - byte to transmit
//   TxD_busy       - transmitter busy
//   RxD_data_ready - receiver holds a completed byte
//   RxD_data       - received byte
//   RxD_clear      - one-cycle acknowledge to the receiver
// STATUS read value: {28'b0, tx_idle, tx_ovf, rx_nonempty, tx_notfull}.
module uart_mmio_ctrl #(
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_mmio_ctrl_if.slave  bus,
  output logic             TxD_start,
  output logic [7:0]       TxD_data,
  input  logic             TxD_busy,
  input  logic             RxD_data_ready,
  input  logic [7:0]       RxD_data,
  output logic             RxD_clear
);

  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam logic [TAW:0] TX_ONE = 1;
  localparam logic [RAW:0] RX_ONE = 1;

  typedef enum logic [1:0] {T_IDLE, T_START, T_HOLD} txState_t;
  typedef enum logic       {R_IDLE, R_CLEAR}         rxState_t;

  txState_t txState, txNext;
  rxState_t rxState, rxNext;

  logic [7:0]   txMem [TX_DEPTH];
  logic [7:0]   rxMem [RX_DEPTH];
  logic [TAW:0] txWr, txRd;
  logic [RAW:0] rxWr, rxRd;
  logic         txOvf;

  logic txFull, txEmpty, rxFull, rxEmpty;
  logic txPush, txPop, rxPush, rxPop;
  logic dataWr, dataRd, statusRd, ovfSet;
  logic txIdle;
  logic [31:0] rdNext;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign txFull  = (txWr[TAW] != txRd[TAW]) && (txWr[TAW-1:0] == txRd[TAW-1:0]);
  assign txEmpty = (txWr == txRd);
  assign rxFull  = (rxWr[RAW] != rxRd[RAW]) && (rxWr[RAW-1:0] == rxRd[RAW-1:0]);
  assign rxEmpty = (rxWr == rxRd);

  assign dataWr   = bus.req &&  bus.we && !bus.addr_sel;
  assign dataRd   = bus.req && !bus.we && !bus.addr_sel;
  assign statusRd = bus.req && !bus.we &&  bus.addr_sel;

  // Full/empty come from pre-cycle pointers: a push on a full FIFO is refused
  // even if a pop frees a slot in the same cycle.
  assign txPush = dataWr && !txFull;
  assign ovfSet = dataWr &&  txFull;
  assign rxPop  = dataRd && !rxEmpty;

  assign txIdle = txEmpty && (txState == T_IDLE) && !TxD_busy;

  // TX launch FSM
  always_comb begin
    txNext    = txState;
    txPop     = 1'b0;
    TxD_start = 1'b0;
    unique case (txState)
      T_IDLE: begin
        if (!txEmpty && !TxD_busy) begin
          txPop  = 1'b1;
          txNext = T_START;
        end
      end
      T_START: begin
        TxD_start = 1'b1;
        txNext    = T_HOLD;
      end
      T_HOLD: begin
        // Busy is already high on the first cycle here; wait for it to drop.
        if (!TxD_busy) txNext = T_IDLE;
      end
      default: txNext = T_IDLE;
    endcase
  end

  // RX drain FSM; withholding the clear while full backpressures the receiver.
  always_comb begin
    rxNext    = rxState;
    rxPush    = 1'b0;
    RxD_clear = 1'b0;
    unique case (rxState)
      R_IDLE: begin
        if (RxD_data_ready && !rxFull) begin
          rxPush = 1'b1;
          rxNext = R_CLEAR;
        end
      end
      R_CLEAR: begin
        RxD_clear = 1'b1;
        rxNext    = R_IDLE;
      end
      default: rxNext = R_IDLE;
    endcase
  end

  always_comb begin
    rdNext = 32'b0;
    if (bus.addr_sel) begin
      rdNext = {28'b0, txIdle, txOvf, !rxEmpty, !txFull};
    end else if (!rxEmpty) begin
      rdNext = {24'b0, rxMem[rxRd[RAW-1:0]]};
    end
  end

  // FIFO storage is plain data and needs no reset.
  always_ff @(posedge clk) begin
    if (txPush) txMem[txWr[TAW-1:0]] <= bus.wdata;
    if (rxPush) rxMem[rxWr[RAW-1:0]] <= RxD_data;
  end

  // Register stage: state, pointers, sticky overflow and the bus response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txState    <= T_IDLE;
      rxState    <= R_IDLE;
      txWr       <= '0;
      txRd       <= '0;
      rxWr       <= '0;
      rxRd       <= '0;
      txOvf      <= 1'b0;
      TxD_data   <= '0;
      bus.rdata  <= '0;
      bus.rvalid <= 1'b0;
    end else begin
      txState <= txNext;
      rxState <= rxNext;
      if (txPush) txWr <= txWr + TX_ONE;
      if (txPop) begin
        txRd     <= txRd + TX_ONE;
        TxD_data <= txMem[txRd[TAW-1:0]];
      end
      if (rxPush) rxWr <= rxWr + RX_ONE;
      if (rxPop)  rxRd <= rxRd + RX_ONE;
      // An overflow in the same cycle as a STATUS read wins, so it is not lost.
      if (ovfSet)        txOvf <= 1'b1;
      else if (statusRd) txOvf <= 1'b0;
      bus.rvalid <= bus.req && !bus.we;
      if (bus.req && !bus.we) bus.rdata <= rdNext;
    end
  end

endmodule
